uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
- Synchronous single-clock FIFO that buffers bytes written by the CPU-side store path and feeds the UART transmit sequencer.
- Its read side sits directly upstream of the transmitter's `fifo_empty` / `fifo_data` / `fifo_read_en` interface.
- Read data is registered: valid the cycle after `fifo_read_en`.
- The write side gives the bus full/almost-full back-pressure, a fill level and a synchronous flush.

Parameters:
- WIDTH, `DATA_WIDTH: data word width in bits.
- DEPTH, 16: number of entries; power of two, ≥ 2.
- AFULL_THRESH, 12: `almost_full` asserts when level ≥ this value; range 1..DEPTH.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  asynchronous reset, active-low (0 = reset).
- wr_en  in  1  write strobe from bus side.
- wr_data  in  WIDTH  write word.
- flush  in  1  synchronous clear of contents.
- full  out  1  level == DEPTH.
- almost_full  out  1  level ≥ AFULL_THRESH.
- level  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- fifo_read_en  in  1  read strobe from transmitter.
- fifo_data  out  WIDTH  registered read word.
- fifo_empty  out  1  level == 0.

Behaviour:
- Storage:
  - DEPTH×WIDTH array.
  - Write pointer `wp` and read pointer `rp`, each $clog2(DEPTH)+1 bits. The extra MSB distinguishes full from empty.
  - Pointers wrap naturally modulo 2·DEPTH.
  - level = wp − rp, modulo 2^(ptr width).
- Reset (rst = 0, asynchronous):
  - wp = rp = 0, fifo_data = 0.
  - fifo_empty = 1, full = 0, almost_full = 0, level = 0.
  - Array contents are don't-care.
  - Reset mid-transfer discards everything; deassertion is synchronised by the system and is not handled here.
- Status outputs (`full`, `almost_full`, `fifo_empty`, `level`) are registered.
  - They reflect the state after the current edge's operations.
  - No combinational path from inputs to outputs.
- Write:
  - Accepted when wr_en = 1 and full = 0 (pre-edge value): mem[wp] ← wr_data, wp += 1.
  - wr_en while full: word dropped, wp unchanged.
- Read:
  - Accepted when fifo_read_en = 1 and fifo_empty = 0 (pre-edge value): fifo_data ← mem[rp], rp += 1.
  - Data is presented the next cycle and held until the next accepted read.
  - fifo_read_en while empty: ignored; fifo_data and rp unchanged.
- Simultaneous read + write:
  - Both accepted per their own conditions in the same cycle; level unchanged.
  - Empty: write accepted, read ignored, so there is no fall-through. The word becomes readable the next cycle and fifo_empty deasserts one cycle after the write edge.
  - Full: read accepted, write dropped; full deasserts next cycle.
- Flush:
  - Sets wp = rp = 0 and clears status as in reset. fifo_data holds its last value.
  - Overrides any wr_en or fifo_read_en in the same cycle; both are discarded.
- Latency:
  - Write to fifo_empty = 0: 1 cycle.
  - fifo_read_en to valid fifo_data: 1 cycle. This matches a consumer that strobes read in one cycle and samples data in the next.
- The consumer never issues a second read in the cycle it samples data; back-to-back reads are nevertheless supported at 1 word/cycle.

Optional Feature:
Macro `UART_TX_FIFO_OVF_EN`.
- Defined: adds ports `overflow` (out, 1) and `ovf_clear` (in, 1).
  - `overflow` reset value 0.
  - Set sticky on the edge after any dropped write (wr_en while full).
  - Cleared by ovf_clear = 1 or flush.
  - If set and clear occur in the same cycle, set wins.
- Undefined: both ports absent; dropped writes are silent.

Test Plan:
- Reset then idle → fifo_empty = 1, full = 0, level = 0, fifo_data = 0; fifo_read_en pulses leave all outputs unchanged.
- Write 0x41, 0x42, 0x43 on consecutive cycles, then three single-cycle reads spaced 2 cycles apart → fifo_data = 0x41, 0x42, 0x43, each one cycle after its read; level steps 1, 2, 3, 2, 1, 0; fifo_empty = 1 after the third read.
- Write 16 words 0x00..0x0F (DEPTH = 16), then write 0xFF → almost_full asserts after the 12th write, full after the 16th; 0xFF is dropped; reading all 16 returns 0x00..0x0F, then empty. With `UART_TX_FIFO_OVF_EN`: overflow = 1 until ovf_clear.
- Full FIFO, wr_en = 1 (0xAA) and fifo_read_en = 1 in the same cycle → read returns the oldest word, 0xAA is dropped, level = 15, full = 0 next cycle.
- Empty FIFO, wr_en = 1 (0x55) and fifo_read_en = 1 together → read ignored, level = 1; read next cycle returns 0x55.
- 40 continuous write/read cycles (pointer wrap past 2·DEPTH) with an incrementing pattern → output sequence matches input with no loss; then flush with wr_en = 1 → level = 0, fifo_empty = 1, the flushed-cycle word is absent.

Source files
------------

// File: rtl/uart_tx_fifo.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module     : uart_tx_fifo
// Description: Single-clock byte FIFO feeding the UART transmit sequencer, with
//              registered read data and registered status. The optional
//              sticky overflow flag is enabled by UART_TX_FIFO_OVF_EN.
// Revision   : 1.0
//------------------------------------------------------------------------------
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module uart_tx_fifo #(
   parameter int WIDTH        = `DATA_WIDTH,
   parameter int DEPTH        = 16,
   parameter int AFULL_THRESH = 12
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     flush,
   output logic                     full,
   output logic                     almost_full,
   output logic [$clog2(DEPTH):0]   level,
   input  logic                     fifo_read_en,
   output logic [WIDTH-1:0]         fifo_data,
   output logic                     fifo_empty
`ifdef UART_TX_FIFO_OVF_EN
   ,
   output logic                     overflow,
   input  logic                     ovf_clear
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam logic [PW-1:0] DEPTH_L = PW'(DEPTH);
   localparam logic [PW-1:0] AFULL_L = PW'(AFULL_THRESH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wp;
   logic [PW-1:0]    rp;
   logic [PW-1:0]    wp_nxt;
   logic [PW-1:0]    rp_nxt;
   logic [PW-1:0]    level_nxt;
   logic             wr_ok;
   logic             rd_ok;

   // Acceptance uses the registered flags, so an empty FIFO never falls through.
   always_comb begin
      wr_ok     = wr_en && !full && !flush;
      rd_ok     = fifo_read_en && !fifo_empty && !flush;
      wp_nxt    = wp + {{(PW-1){1'b0}}, wr_ok};
      rp_nxt    = rp + {{(PW-1){1'b0}}, rd_ok};
      if (flush) begin
         wp_nxt = '0;
         rp_nxt = '0;
      end
      level_nxt = wp_nxt - rp_nxt;
   end

   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem[wp[AW-1:0]] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wp          <= '0;
         rp          <= '0;
         level       <= '0;
         full        <= 1'b0;
         almost_full <= 1'b0;
         fifo_empty  <= 1'b1;
         fifo_data   <= '0;
      end else begin
         wp          <= wp_nxt;
         rp          <= rp_nxt;
         level       <= level_nxt;
         full        <= (level_nxt == DEPTH_L);
         almost_full <= (level_nxt >= AFULL_L);
         fifo_empty  <= (level_nxt == '0);
         if (rd_ok) begin
            fifo_data <= mem[rp[AW-1:0]];
         end
      end
   end

`ifdef UART_TX_FIFO_OVF_EN
   // A drop in the same cycle as a clear leaves the flag set.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         overflow <= 1'b0;
      end else if (wr_en && full) begin
         overflow <= 1'b1;
      end else if (ovf_clear || flush) begin
         overflow <= 1'b0;
      end
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// Self-checking bench for uart_tx_fifo: queue-based reference model compared
// every cycle, plus directed literal checks and a randomized phase.
`timescale 1ns/1ps

module tb_uart_tx_fifo;

   localparam int WIDTH = 8;
   localparam int DEPTH = 16;
   localparam int AFT   = 12;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             wr_en = 1'b0;
   logic [WIDTH-1:0] wr_data = '0;
   logic             flush = 1'b0;
   logic             fifo_read_en = 1'b0;
   logic             full;
   logic             almost_full;
   logic [4:0]       level;
   logic [WIDTH-1:0] fifo_data;
   logic             fifo_empty;
`ifdef UART_TX_FIFO_OVF_EN
   logic             overflow;
   logic             ovf_clear = 1'b0;
`endif

   int n_cmp = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   logic [WIDTH-1:0] q[$];
   logic [WIDTH-1:0] m_data;

   uart_tx_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AFULL_THRESH(AFT)) dut (
      .clk          (clk),
      .rst          (rst),
      .wr_en        (wr_en),
      .wr_data      (wr_data),
      .flush        (flush),
      .full         (full),
      .almost_full  (almost_full),
      .level        (level),
      .fifo_read_en (fifo_read_en),
      .fifo_data    (fifo_data),
      .fifo_empty   (fifo_empty)
`ifdef UART_TX_FIFO_OVF_EN
      ,
      .overflow     (overflow),
      .ovf_clear    (ovf_clear)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a queue of stored words and the last word handed out.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         q.delete();
         m_data = '0;
      end else if (flush) begin
         q.delete();
      end else begin
         bit do_rd;
         bit do_wr;
         do_rd = fifo_read_en && (q.size() > 0);
         do_wr = wr_en && (q.size() < DEPTH);
         if (do_rd) m_data = q.pop_front();
         if (do_wr) q.push_back(wr_data);
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("model_level", 32'(level), 32'(q.size()));
         check("model_full", 32'(full), 32'(q.size() == DEPTH));
         check("model_afull", 32'(almost_full), 32'(q.size() >= AFT));
         check("model_empty", 32'(fifo_empty), 32'(q.size() == 0));
         check("model_data", 32'(fifo_data), 32'(m_data));
      end
   end

   task automatic step(input logic we, input logic [WIDTH-1:0] d, input logic re, input logic fl);
      wr_en        = we;
      wr_data      = d;
      fifo_read_en = re;
      flush        = fl;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_empty", 32'(fifo_empty), 32'd1);
      check("rst_full", 32'(full), 32'd0);
      check("rst_level", 32'(level), 32'd0);
      check("rst_data", 32'(fifo_data), 32'd0);
      rst = 1'b1;
      chk_en = 1'b1;

      // Idle reads on an empty FIFO change nothing.
      step(0, 8'h00, 1, 0);
      step(0, 8'h00, 1, 0);
      check("idle_rd_data", 32'(fifo_data), 32'd0);
      check("idle_rd_empty", 32'(fifo_empty), 32'd1);

      // Three writes, three spaced reads.
      step(1, 8'h41, 0, 0); check("w1_level", 32'(level), 32'd1);
      check("w1_empty", 32'(fifo_empty), 32'd0);
      step(1, 8'h42, 0, 0); check("w2_level", 32'(level), 32'd2);
      step(1, 8'h43, 0, 0); check("w3_level", 32'(level), 32'd3);
      step(0, 8'h00, 1, 0); check("r1_data", 32'(fifo_data), 32'h41);
      check("r1_level", 32'(level), 32'd2);
      step(0, 8'h00, 0, 0);
      step(0, 8'h00, 1, 0); check("r2_data", 32'(fifo_data), 32'h42);
      check("r2_level", 32'(level), 32'd1);
      step(0, 8'h00, 0, 0);
      step(0, 8'h00, 1, 0); check("r3_data", 32'(fifo_data), 32'h43);
      check("r3_empty", 32'(fifo_empty), 32'd1);

      // Fill to full, then a dropped write.
      for (int i = 0; i < DEPTH; i++) begin
         step(1, 8'(i), 0, 0);
         if (i == 10) check("afull_11", 32'(almost_full), 32'd0);
         if (i == 11) check("afull_12", 32'(almost_full), 32'd1);
         if (i == 14) check("full_15", 32'(full), 32'd0);
      end
      check("full_16", 32'(full), 32'd1);
      step(1, 8'hFF, 0, 0);
      check("drop_level", 32'(level), 32'd16);
`ifdef UART_TX_FIFO_OVF_EN
      check("ovf_set", 32'(overflow), 32'd1);
      ovf_clear = 1'b1;
      step(0, 8'h00, 0, 0);
      ovf_clear = 1'b0;
      check("ovf_clr", 32'(overflow), 32'd0);
`endif

      // Simultaneous read and write while full.
      step(1, 8'hAA, 1, 0);
      check("fullrw_data", 32'(fifo_data), 32'h00);
      check("fullrw_level", 32'(level), 32'd15);
      check("fullrw_full", 32'(full), 32'd0);
      for (int i = 1; i < DEPTH; i++) begin
         step(0, 8'h00, 1, 0);
         check("drain_data", 32'(fifo_data), 32'(i));
      end
      check("drain_empty", 32'(fifo_empty), 32'd1);

      // Simultaneous read and write while empty: no fall-through.
      step(1, 8'h55, 1, 0);
      check("emptyrw_level", 32'(level), 32'd1);
      check("emptyrw_data", 32'(fifo_data), 32'h0F);
      step(0, 8'h00, 1, 0);
      check("emptyrw_rd", 32'(fifo_data), 32'h55);

      // Streaming past pointer wrap, then flush with a concurrent write.
      step(1, 8'h00, 0, 0);
      for (int i = 1; i < 40; i++) begin
         step(1, 8'(i), 1, 0);
         check("stream_data", 32'(fifo_data), 32'(i - 1));
         check("stream_level", 32'(level), 32'd1);
      end
      step(1, 8'hEE, 1, 1);
      check("flush_level", 32'(level), 32'd0);
      check("flush_empty", 32'(fifo_empty), 32'd1);
      check("flush_hold", 32'(fifo_data), 32'd38);
      step(0, 8'h00, 1, 0);
      check("flush_noword", 32'(fifo_data), 32'd38);

      // Randomized traffic, alternating between fill-biased and drain-biased.
      for (int i = 0; i < 600; i++) begin
         int wp_pct;
         wp_pct = ((i / 50) % 2 == 0) ? 75 : 30;
         step(($urandom_range(0, 99) < wp_pct), 8'($urandom),
              ($urandom_range(0, 99) < (100 - wp_pct)), ($urandom_range(0, 63) == 0));
      end
      step(0, 8'h00, 0, 0);

      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
